pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: boot hold, load-use, redirect, dmem wait, timeout halt.
// Optional perf counters enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
   parameter int BOOT_CYCLES = 4,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs1_iss,
   input  logic [4:0]  rs2_iss,
   input  logic        uses_rs1_iss,
   input  logic        uses_rs2_iss,
   input  logic [4:0]  rd_ex,
   input  logic        reg_wr_ex,
   input  logic        is_load_ex,
   input  logic        branch_taken_ex,
   input  logic        dmem_req_mem,
   input  logic        dmem_ack_mem,
   output logic        stall_fetch,
   output logic        stall_iss,
   output logic        stall_ex,
   output logic        stall_mem,
   output logic        flush_iss,
   output logic        flush_ex,
   output logic        wb_bubble,
   output logic        redirect,
   output logic        mem_err,
   output logic        halted,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_flushes,
   output logic [31:0] perf_load_use
);

   localparam int BW = $clog2(BOOT_CYCLES + 1);
   localparam int WW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      HALT     = 2'd3
   } state_t;

   state_t          state_r;
   state_t          next_state_s;
   logic [BW-1:0]   boot_cnt_r;
   logic [WW-1:0]   wait_cnt_r;
   logic            mem_err_r;
   logic            mem_hold_s;
   logic            hazard_s;
   logic            resolve_s;
   logic            lu_fire_s;
   logic            timeout_s;
   logic            freeze_s;

   assign mem_hold_s = dmem_req_mem & ~dmem_ack_mem;
   assign hazard_s   = is_load_ex & reg_wr_ex & (rd_ex != 5'd0) &
                       ((uses_rs1_iss & (rs1_iss == rd_ex)) | (uses_rs2_iss & (rs2_iss == rd_ex)));
   assign mem_err    = mem_err_r;

   // Next-state and output decode; a branch kills the issue slot, so it outranks load-use.
   always_comb begin
      next_state_s = state_r;
      resolve_s    = 1'b0;
      timeout_s    = 1'b0;
      freeze_s     = 1'b0;
      lu_fire_s    = 1'b0;
      stall_fetch  = 1'b0;
      stall_iss    = 1'b0;
      stall_ex     = 1'b0;
      stall_mem    = 1'b0;
      flush_iss    = 1'b0;
      flush_ex     = 1'b0;
      wb_bubble    = 1'b0;
      redirect     = 1'b0;
      halted       = 1'b0;
      case (state_r)
         BOOT: begin
            freeze_s  = 1'b1;
            flush_iss = 1'b1;
            flush_ex  = 1'b1;
            if (boot_cnt_r == BW'(BOOT_CYCLES - 1)) begin
               next_state_s = RUN;
            end else begin
               next_state_s = BOOT;
            end
         end
         RUN: begin
            if (mem_hold_s) begin
               freeze_s     = 1'b1;
               next_state_s = MEM_WAIT;
            end else begin
               resolve_s    = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (dmem_ack_mem) begin
               resolve_s    = 1'b1;
               next_state_s = RUN;
            end else if (wait_cnt_r == WW'(MEM_TIMEOUT - 1)) begin
               freeze_s     = 1'b1;
               timeout_s    = 1'b1;
               next_state_s = HALT;
            end else begin
               freeze_s     = 1'b1;
            end
         end
         HALT: begin
            freeze_s = 1'b1;
            halted   = 1'b1;
         end
         default: begin
            freeze_s     = 1'b1;
            next_state_s = BOOT;
         end
      endcase

      if (resolve_s) begin
         lu_fire_s = ~branch_taken_ex & hazard_s;
         redirect  = branch_taken_ex;
         flush_iss = branch_taken_ex;
         flush_ex  = branch_taken_ex | lu_fire_s;
      end else begin
         lu_fire_s = 1'b0;
      end

      if (freeze_s) begin
         stall_fetch = 1'b1;
         stall_iss   = 1'b1;
         stall_ex    = 1'b1;
         stall_mem   = 1'b1;
         wb_bubble   = 1'b1;
      end else begin
         stall_fetch = lu_fire_s;
         stall_iss   = lu_fire_s;
      end
   end

   // State register, boot/wait counters and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= BOOT;
         boot_cnt_r <= BW'(0);
         wait_cnt_r <= WW'(0);
         mem_err_r  <= 1'b0;
      end else begin
         state_r <= next_state_s;
         if ((state_r == BOOT) && (boot_cnt_r != BW'(BOOT_CYCLES))) begin
            boot_cnt_r <= boot_cnt_r + BW'(1);
         end
         case (state_r)
            RUN:      wait_cnt_r <= mem_hold_s ? WW'(1) : WW'(0);
            MEM_WAIT: begin
               if (dmem_ack_mem) begin
                  wait_cnt_r <= WW'(0);
               end else if (wait_cnt_r != WW'(MEM_TIMEOUT)) begin
                  wait_cnt_r <= wait_cnt_r + WW'(1);
               end
            end
            default:  wait_cnt_r <= wait_cnt_r;
         endcase
         if (timeout_s) begin
            mem_err_r <= 1'b1;
         end
      end
   end

`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] perf_stall_r;
   logic [31:0] perf_flush_r;
   logic [31:0] perf_lu_r;
   logic        active_s;

   assign active_s = (state_r == RUN) | (state_r == MEM_WAIT);

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stall_r <= 32'd0;
         perf_flush_r <= 32'd0;
         perf_lu_r    <= 32'd0;
      end else begin
         if (active_s && stall_fetch && (perf_stall_r != 32'hFFFF_FFFF)) begin
            perf_stall_r <= perf_stall_r + 32'd1;
         end
         if (redirect && (perf_flush_r != 32'hFFFF_FFFF)) begin
            perf_flush_r <= perf_flush_r + 32'd1;
         end
         if (lu_fire_s && (perf_lu_r != 32'hFFFF_FFFF)) begin
            perf_lu_r <= perf_lu_r + 32'd1;
         end
      end
   end

   assign perf_stall_cycles = perf_stall_r;
   assign perf_flushes      = perf_flush_r;
   assign perf_load_use     = perf_lu_r;
`else
   assign perf_stall_cycles = 32'd0;
   assign perf_flushes      = 32'd0;
   assign perf_load_use     = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a cycle-level reference model of the sequencing rules.
module tb_pipe_hazard_ctrl;
   localparam int BOOT_N = 4;
   localparam int TMO_N  = 8;

   logic clk_tb = 1'b0;
   always #5 clk_tb = ~clk_tb;

   logic        reset;
   logic [4:0]  rs1_iss, rs2_iss, rd_ex;
   logic        uses_rs1_iss, uses_rs2_iss, reg_wr_ex, is_load_ex;
   logic        branch_taken_ex, dmem_req_mem, dmem_ack_mem;
   logic        stall_fetch, stall_iss, stall_ex, stall_mem;
   logic        flush_iss, flush_ex, wb_bubble, redirect, mem_err, halted;
   logic [31:0] perf_stall_cycles, perf_flushes, perf_load_use;

   pipe_hazard_ctrl #(.BOOT_CYCLES(BOOT_N), .MEM_TIMEOUT(TMO_N)) dut (
      .clk(clk_tb), .reset(reset),
      .rs1_iss(rs1_iss), .rs2_iss(rs2_iss),
      .uses_rs1_iss(uses_rs1_iss), .uses_rs2_iss(uses_rs2_iss),
      .rd_ex(rd_ex), .reg_wr_ex(reg_wr_ex), .is_load_ex(is_load_ex),
      .branch_taken_ex(branch_taken_ex),
      .dmem_req_mem(dmem_req_mem), .dmem_ack_mem(dmem_ack_mem),
      .stall_fetch(stall_fetch), .stall_iss(stall_iss),
      .stall_ex(stall_ex), .stall_mem(stall_mem),
      .flush_iss(flush_iss), .flush_ex(flush_ex),
      .wb_bubble(wb_bubble), .redirect(redirect),
      .mem_err(mem_err), .halted(halted),
      .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes),
      .perf_load_use(perf_load_use)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: cycles spent booting, consecutive memory wait cycles, halt/error flags.
   int          boot_seen;
   int          waited;
   bit          halt_m;
   bit          err_m;
   int unsigned m_stall, m_flush, m_lu;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step(input bit do_chk);
      bit boot, wait_ph, run, hold, resolve, lu, br, ack, all_hold;
      bit e_sf, e_fi, e_fe, e_red;
      @(negedge clk_tb);
      boot    = boot_seen < BOOT_N;
      wait_ph = !boot && !halt_m && waited > 0;
      run     = !boot && !halt_m && waited == 0;
      ack     = dmem_ack_mem;
      br      = branch_taken_ex;
      hold    = run && dmem_req_mem && !ack;
      resolve = (run && !hold) || (wait_ph && ack);
      lu      = is_load_ex && reg_wr_ex && rd_ex != 5'd0 &&
                ((uses_rs1_iss && rs1_iss == rd_ex) || (uses_rs2_iss && rs2_iss == rd_ex));
      all_hold = boot || halt_m || (wait_ph && !ack) || hold;
      e_sf  = all_hold || (resolve && !br && lu);
      e_fi  = boot || (resolve && br);
      e_fe  = boot || (resolve && (br || lu));
      e_red = resolve && br;
      if (do_chk) begin
         check_eq("stall_fetch", stall_fetch, e_sf);
         check_eq("stall_iss",   stall_iss,   e_sf);
         check_eq("stall_ex",    stall_ex,    all_hold);
         check_eq("stall_mem",   stall_mem,   all_hold);
         check_eq("wb_bubble",   wb_bubble,   all_hold);
         check_eq("flush_iss",   flush_iss,   e_fi);
         check_eq("flush_ex",    flush_ex,    e_fe);
         check_eq("redirect",    redirect,    e_red);
         check_eq("halted",      halted,      halt_m);
         check_eq("mem_err",     mem_err,     err_m);
`ifdef PIPE_HAZARD_PERF_EN
         check_eq("perf_stall",  perf_stall_cycles, m_stall);
         check_eq("perf_flush",  perf_flushes,      m_flush);
         check_eq("perf_lu",     perf_load_use,     m_lu);
`else
         check_eq("perf_stall",  perf_stall_cycles, 32'd0);
         check_eq("perf_flush",  perf_flushes,      32'd0);
         check_eq("perf_lu",     perf_load_use,     32'd0);
`endif
      end
      if (reset) begin
         boot_seen = 0; waited = 0; halt_m = 1'b0; err_m = 1'b0;
         m_stall = 0; m_flush = 0; m_lu = 0;
      end else begin
         if ((run || wait_ph) && e_sf) m_stall++;
         if (e_red) m_flush++;
         if (resolve && !br && lu) m_lu++;
         if (boot) begin
            boot_seen++;
         end else if (halt_m) begin
            halt_m = 1'b1;
         end else if (wait_ph) begin
            if (ack) waited = 0;
            else if (waited == TMO_N - 1) begin halt_m = 1'b1; err_m = 1'b1; end
            else waited++;
         end else if (hold) begin
            waited = 1;
         end
      end
      @(posedge clk_tb);
      #1;
   endtask

   task automatic idle_inputs();
      rs1_iss = 5'd0; rs2_iss = 5'd0; rd_ex = 5'd0;
      uses_rs1_iss = 1'b0; uses_rs2_iss = 1'b0; reg_wr_ex = 1'b0; is_load_ex = 1'b0;
      branch_taken_ex = 1'b0; dmem_req_mem = 1'b0; dmem_ack_mem = 1'b0;
   endtask

   task automatic load_use_inputs(input logic [4:0] rd);
      idle_inputs();
      is_load_ex = 1'b1; reg_wr_ex = 1'b1; rd_ex = rd;
      rs2_iss = 5'd5; uses_rs2_iss = 1'b1;
   endtask

   task automatic rand_inputs(input int ack_pct, input int req_pct);
      rs1_iss = 5'($urandom_range(0, 3)); rs2_iss = 5'($urandom_range(0, 3));
      rd_ex   = 5'($urandom_range(0, 3));
      uses_rs1_iss = 1'($urandom); uses_rs2_iss = 1'($urandom);
      reg_wr_ex = 1'($urandom); is_load_ex = 1'($urandom);
      branch_taken_ex = ($urandom_range(0, 99) < 20);
      dmem_req_mem    = ($urandom_range(0, 99) < req_pct);
      dmem_ack_mem    = ($urandom_range(0, 99) < ack_pct);
      reset           = ($urandom_range(0, 99) < 2);
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      boot_seen = 0; waited = 0; halt_m = 1'b0; err_m = 1'b0;
      m_stall = 0; m_flush = 0; m_lu = 0;
      step(1'b0);
      step(1'b1);
      step(1'b1);
      reset = 1'b0;
      for (int i = 0; i < BOOT_N + 1; i++) step(1'b1);
      // Directed: load-use, rd_ex=0, branch over load-use.
      load_use_inputs(5'd5); step(1'b1);
      idle_inputs();         step(1'b1);
      load_use_inputs(5'd0); step(1'b1);
      load_use_inputs(5'd5); branch_taken_ex = 1'b1; step(1'b1);
      // Directed: three wait cycles then ack.
      idle_inputs(); dmem_req_mem = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1);
      dmem_ack_mem = 1'b1; step(1'b1);
      idle_inputs(); step(1'b1);
      // Directed: timeout into HALT, then reset recovery.
      dmem_req_mem = 1'b1;
      for (int i = 0; i < TMO_N + 4; i++) step(1'b1);
      reset = 1'b1; step(1'b1);
      reset = 1'b0; idle_inputs(); step(1'b1);
      for (int i = 0; i < BOOT_N; i++) step(1'b1);
      // Random phases: mostly-acked traffic, then slow memory that times out.
      for (int i = 0; i < 600; i++) begin rand_inputs(45, 40); step(1'b1); end
      for (int i = 0; i < 600; i++) begin rand_inputs(6, 60); step(1'b1); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
